// File: rtl/pwm_ramp_gen.sv
// Sawtooth ramp and period-aligned reference for a registered >= comparator.
// Reference writes are double-buffered and take effect only at period boundaries.
module pwm_ramp_gen #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned TOP      = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] ref_in,
   input  logic             ref_load,
   output logic [WIDTH-1:0] ramp,
   output logic [WIDTH-1:0] ref_out,
   output logic             period_start,
   output logic             ref_ack,
   output logic             busy
);

   localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] RAMP_TOP = WIDTH'(TOP);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           state_q;
   logic [PW-1:0]    presc_q;
   logic [WIDTH-1:0] shadow_q;
   logic             pending_q;

   logic step;
   logic boundary;
   logic xfer;

   always_comb begin
      step     = (state_q != StIdle) && (presc_q == PRE_LAST);
      boundary = step && (ramp == RAMP_TOP);
      // DRAIN boundaries deliberately do not transfer, so a pending value survives to restart
      xfer     = ((state_q == StIdle) && en) || ((state_q == StRun) && boundary);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         presc_q      <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         ramp         <= '0;
         ref_out      <= '0;
         period_start <= 1'b0;
         ref_ack      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         period_start <= 1'b0;
         ref_ack      <= 1'b0;

         if (ref_load) begin
            shadow_q  <= ref_in;
            pending_q <= 1'b1;
         end

         // A load coinciding with the transfer point bypasses the shadow
         if (xfer) begin
            if (ref_load) begin
               ref_out   <= ref_in;
               ref_ack   <= 1'b1;
               pending_q <= 1'b0;
            end else if (pending_q) begin
               ref_out   <= shadow_q;
               ref_ack   <= 1'b1;
               pending_q <= 1'b0;
            end
         end

         unique case (state_q)
            StIdle: begin
               ramp    <= '0;
               presc_q <= '0;
               if (en) begin
                  state_q      <= StRun;
                  busy         <= 1'b1;
                  period_start <= 1'b1;
               end
            end
            StRun, StDrain: begin
               if (step) begin
                  presc_q <= '0;
                  ramp    <= boundary ? '0 : ramp + 1'b1;
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
               if (state_q == StRun) begin
                  if (boundary) period_start <= 1'b1;
                  if (!en) state_q <= StDrain;
               end else if (boundary) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else if (en) begin
                  state_q <= StRun;
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Directed bench for pwm_ramp_gen: default instance plus a PRESCALE=1 instance.
module tb_pwm_ramp_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] ref_in;
   logic       ref_load;
   logic [3:0] ramp;
   logic [3:0] ref_out;
   logic       period_start;
   logic       ref_ack;
   logic       busy;

   logic       en1;
   logic [3:0] ref_in1;
   logic       ref_load1;
   logic [3:0] ramp1;
   logic [3:0] ref_out1;
   logic       period_start1;
   logic       ref_ack1;
   logic       busy1;

   int checks = 0;
   int errors = 0;

   logic [10:0] obs;
   logic [10:0] want;

   always #5 clk = ~clk;

   pwm_ramp_gen #(.WIDTH(4), .PRESCALE(4), .TOP(15)) dut (
      .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .ref_load(ref_load),
      .ramp(ramp), .ref_out(ref_out), .period_start(period_start), .ref_ack(ref_ack),
      .busy(busy)
   );

   pwm_ramp_gen #(.WIDTH(4), .PRESCALE(1), .TOP(15)) dut_p1 (
      .clk(clk), .rst(rst), .en(en1), .ref_in(ref_in1), .ref_load(ref_load1),
      .ramp(ramp1), .ref_out(ref_out1), .period_start(period_start1), .ref_ack(ref_ack1),
      .busy(busy1)
   );

   // Snapshot order: {busy, ramp, ref_out, period_start, ref_ack}
   function automatic logic [10:0] snap();
      return {busy, ramp, ref_out, period_start, ref_ack};
   endfunction

   function automatic logic [10:0] pk(input logic b, input logic [3:0] r, input logic [3:0] o,
                                      input logic p, input logic a);
      return {b, r, o, p, a};
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; ref_in = '0; ref_load = 1'b0;
      en1 = 1'b0; ref_in1 = '0; ref_load1 = 1'b0;
      tick(2);
      rst = 1'b0;
      obs = snap(); want = pk(0, 0, 0, 0, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL reset: got %b want %b", obs, want);
      end
      tick(3);
      obs = snap(); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL reset_idle_hold: got %b want %b", obs, want);
      end
   endtask

   // Ends at E64 (second period start, prescaler 0)
   task automatic test_start();
      ref_in = 4'd5; ref_load = 1'b1;
      tick(1);
      ref_load = 1'b0;
      obs = snap(); want = pk(0, 0, 0, 0, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL load_in_idle: got %b want %b", obs, want);
      end
      en = 1'b1;
      tick(1);
      obs = snap(); want = pk(1, 0, 5, 1, 1); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL start_edge: got %b want %b", obs, want);
      end
      tick(3);
      obs = snap(); want = pk(1, 0, 5, 0, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL hold_ramp0: got %b want %b", obs, want);
      end
      tick(1);
      checks++;
      if (ramp !== 4'd1) begin
         errors++; $display("FAIL ramp_after4: got %0d want 1", ramp);
      end
      tick(56);
      checks++;
      if (ramp !== 4'd15) begin
         errors++; $display("FAIL ramp_after60: got %0d want 15", ramp);
      end
      tick(3);
      checks++;
      if (ramp !== 4'd15 || period_start !== 1'b0) begin
         errors++; $display("FAIL ramp_after63: got %0d/%0b want 15/0", ramp, period_start);
      end
      tick(1);
      obs = snap(); want = pk(1, 0, 5, 1, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL wrap64: got %b want %b", obs, want);
      end
   endtask

   // Starts at E64, ends at E129
   task automatic test_mid_period_loads();
      int acks;
      tick(20);
      ref_in = 4'd9; ref_load = 1'b1;
      tick(1);
      ref_in = 4'd12;
      tick(1);
      ref_load = 1'b0;
      checks++;
      if (ref_out !== 4'd5 || ref_ack !== 1'b0) begin
         errors++; $display("FAIL midload_hold: got ref=%0d ack=%0b want 5/0", ref_out, ref_ack);
      end
      acks = 0;
      for (int i = 0; i < 41; i++) begin
         tick(1);
         if (ref_ack) acks++;
      end
      checks++;
      if (acks !== 0 || ref_out !== 4'd5 || ramp !== 4'd15) begin
         errors++;
         $display("FAIL midload_before_wrap: got acks=%0d ref=%0d ramp=%0d want 0/5/15",
                  acks, ref_out, ramp);
      end
      tick(1);
      obs = snap(); want = pk(1, 0, 12, 1, 1); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL midload_wrap: got %b want %b", obs, want);
      end
      tick(1);
      checks++;
      if (ref_ack !== 1'b0 || ref_out !== 4'd12) begin
         errors++; $display("FAIL midload_single_ack: got ack=%0b ref=%0d want 0/12",
                            ref_ack, ref_out);
      end
   endtask

   // Starts at E129, ends at E256
   task automatic test_boundary_load();
      tick(62);
      checks++;
      if (ramp !== 4'd15) begin
         errors++; $display("FAIL bload_pre: got ramp=%0d want 15", ramp);
      end
      ref_in = 4'd3; ref_load = 1'b1;
      tick(1);
      ref_load = 1'b0;
      obs = snap(); want = pk(1, 0, 3, 1, 1); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL bypass_wrap: got %b want %b", obs, want);
      end
      tick(64);
      obs = snap(); want = pk(1, 0, 3, 1, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL bypass_no_pending: got %b want %b", obs, want);
      end
   endtask

   task automatic test_drain();
      int ps;
      tick(28);
      checks++;
      if (ramp !== 4'd7) begin
         errors++; $display("FAIL drain_pre: got ramp=%0d want 7", ramp);
      end
      en = 1'b0;
      tick(1);
      ref_in = 4'd7; ref_load = 1'b1;
      tick(1);
      ref_load = 1'b0;
      ps = 0;
      for (int i = 0; i < 33; i++) begin
         tick(1);
         if (period_start) ps++;
      end
      checks++;
      if (ps !== 0 || ramp !== 4'd15 || busy !== 1'b1) begin
         errors++; $display("FAIL drain_count: got ps=%0d ramp=%0d busy=%0b want 0/15/1",
                            ps, ramp, busy);
      end
      tick(1);
      obs = snap(); want = pk(0, 0, 3, 0, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL drain_end: got %b want %b", obs, want);
      end
      tick(5);
      obs = snap(); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL drain_idle: got %b want %b", obs, want);
      end
      en = 1'b1;
      tick(1);
      obs = snap(); want = pk(1, 0, 7, 1, 1); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL restart_pending: got %b want %b", obs, want);
      end
      tick(28);
      en = 1'b0;
      tick(12);
      checks++;
      if (ramp !== 4'd10 || busy !== 1'b1) begin
         errors++; $display("FAIL drain2_ramp: got ramp=%0d busy=%0b want 10/1", ramp, busy);
      end
      en = 1'b1;
      tick(23);
      checks++;
      if (ramp !== 4'd15 || period_start !== 1'b0) begin
         errors++; $display("FAIL rerun_pre: got ramp=%0d ps=%0b want 15/0", ramp, period_start);
      end
      tick(1);
      obs = snap(); want = pk(1, 0, 7, 1, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL rerun_wrap: got %b want %b", obs, want);
      end
   endtask

   task automatic test_reset_mid();
      tick(36);
      checks++;
      if (ramp !== 4'd9) begin
         errors++; $display("FAIL rmid_pre: got ramp=%0d want 9", ramp);
      end
      ref_in = 4'd11; ref_load = 1'b1;
      tick(1);
      ref_load = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      obs = snap(); want = pk(0, 0, 0, 0, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL rmid_reset: got %b want %b", obs, want);
      end
      tick(1);
      obs = snap(); want = pk(1, 0, 0, 1, 0); checks++;
      if (obs !== want) begin
         errors++; $display("FAIL rmid_restart: got %b want %b", obs, want);
      end
      en = 1'b0;
   endtask

   task automatic test_prescale1();
      int bad;
      logic [3:0] er;
      logic       ep;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      en1 = 1'b1;
      tick(1);
      checks++;
      if (ramp1 !== 4'd0 || period_start1 !== 1'b1 || busy1 !== 1'b1) begin
         errors++; $display("FAIL p1_start: got ramp=%0d ps=%0b busy=%0b want 0/1/1",
                            ramp1, period_start1, busy1);
      end
      bad = 0;
      for (int k = 1; k <= 128; k++) begin
         tick(1);
         er = 4'(k % 16);
         ep = (k % 16) == 0;
         checks++;
         if (ramp1 !== er || period_start1 !== ep) begin
            errors++; bad++;
            if (bad <= 5)
               $display("FAIL p1_cycle%0d: got ramp=%0d ps=%0b want %0d/%0b",
                        k, ramp1, period_start1, er, ep);
         end
      end
      en1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_mid_period_loads();
      test_boundary_load();
      test_drain();
      test_reset_mid();
      test_prescale1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
